fetch_ctrl: RTL and testbench

Instruction-fetch controller for the 5-stage RV64 pipeline. Sits between the PC register and the instruction-memory bus. Issues one fetch per PC over a valid/ready request channel and captures the returned instruction. Drives `regF_stall` so the PC advances only after decode accepts the instruction, and discards stale responses after an execute-stage redirect.

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/fetch_hold_buf.sv | 45 ++++
 rtl/fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_fetch_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM state
// encoding, the canonical NOP, and the reset PC shared with the PC register.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam logic [63:0] RESET_PC = 64'h80000000;

endpackage

// File: rtl/fetch_hold_buf.sv
// Holding register for the fetched instruction, its PC and the misalign flag.
// The PC/flag and the instruction load independently so the PC can be
// captured at request acceptance and the instruction at response time.
module fetch_hold_buf #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              pc_we_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              mis_i,
  input  logic              instr_we_i,
  input  logic [INST_W-1:0] instr_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] instr_o,
  output logic              mis_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [INST_W-1:0] instr_q;
  logic              mis_q;

  // Buffer registers: synchronous clear wins over either load.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      pc_q    <= '0;
      instr_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (pc_we_i) begin
        pc_q  <= pc_i;
        mis_q <= mis_i;
      end
      if (instr_we_i) begin
        instr_q <= instr_i;
      end
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign mis_o   = mis_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one outstanding request on the imem bus,
// buffers the returned instruction for decode, holds the PC register until
// decode accepts, and drains stale responses after an execute redirect.
// Optional feature macro: FETCH_CTRL_MISALIGN_EN (misaligned PC short-cuts
// to HOLD with a NOP and the misalign flag set, without a bus request).
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              execute_i_need_jump,
  input  logic              regD_stall,
  output logic              regF_stall,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              fetch_o_valid,
  output logic [INST_W-1:0] fetch_o_instr,
  output logic [ADDR_W-1:0] fetch_o_pc,
  output logic              fetch_o_misalign
);

  fetch_state_e      state_q, state_d;
  logic              pc_we, instr_we, mis_d, misaligned;
  logic [INST_W-1:0] instr_d;
  logic              buf_mis;

`ifdef FETCH_CTRL_MISALIGN_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign imem_req_addr = pc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= REQ;
    else     state_q <= state_d;
  end

  // Next state, bus/decode handshakes and buffer load enables.
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    fetch_o_valid  = 1'b0;
    regF_stall     = 1'b1;
    pc_we          = 1'b0;
    instr_we       = 1'b0;
    mis_d          = 1'b0;
    instr_d        = imem_resp_data;
    unique case (state_q)
      REQ: begin
        if (execute_i_need_jump) begin
          state_d = REQ;
        end else if (misaligned) begin
          state_d  = HOLD;
          pc_we    = 1'b1;
          mis_d    = 1'b1;
          instr_we = 1'b1;
          instr_d  = INST_W'(NOP_INST);
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) begin
            state_d = WAIT;
            pc_we   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (execute_i_need_jump) begin
            state_d = REQ;
          end else begin
            state_d  = HOLD;
            instr_we = 1'b1;
          end
        end else if (execute_i_need_jump) begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        fetch_o_valid = 1'b1;
        if (execute_i_need_jump) begin
          state_d = REQ;
        end else if (!regD_stall) begin
          state_d    = REQ;
          regF_stall = 1'b0;
        end
      end
      DRAIN: begin
        if (imem_resp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
    // The PC register prioritises stall over jump, so release it on redirects.
    if (execute_i_need_jump) regF_stall = 1'b0;
    if (rst) begin
      imem_req_valid = 1'b0;
      fetch_o_valid  = 1'b0;
      regF_stall     = 1'b0;
      pc_we          = 1'b0;
      instr_we       = 1'b0;
    end
  end

  fetch_hold_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_hold_buf (
    .clk_i      (clk),
    .clear_i    (rst),
    .pc_we_i    (pc_we),
    .pc_i       (pc),
    .mis_i      (mis_d),
    .instr_we_i (instr_we),
    .instr_i    (instr_d),
    .pc_o       (fetch_o_pc),
    .instr_o    (fetch_o_instr),
    .mis_o      (buf_mis)
  );

`ifdef FETCH_CTRL_MISALIGN_EN
  assign fetch_o_misalign = buf_mis;
`else
  assign fetch_o_misalign = 1'b0;
  logic unused_mis;
  assign unused_mis = buf_mis;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl. Expected {pc, instr} pairs are queued
// when a request is accepted and popped when decode takes the instruction.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, jump, dstall, ready, resp_valid;
  logic [63:0] pc;
  logic [31:0] resp_data;
  logic        regF_stall, imem_req_valid, fetch_o_valid, fetch_o_misalign;
  logic [63:0] imem_req_addr, fetch_o_pc;
  logic [31:0] fetch_o_instr;

  int errors = 0;
  int checks = 0;
  logic [95:0] sb[$];
  logic [95:0] exp_e;

  fetch_ctrl #(.ADDR_W(64), .INST_W(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc                  (pc),
    .execute_i_need_jump (jump),
    .regD_stall          (dstall),
    .regF_stall          (regF_stall),
    .imem_req_valid      (imem_req_valid),
    .imem_req_addr       (imem_req_addr),
    .imem_req_ready      (ready),
    .imem_resp_valid     (resp_valid),
    .imem_resp_data      (resp_data),
    .fetch_o_valid       (fetch_o_valid),
    .fetch_o_instr       (fetch_o_instr),
    .fetch_o_pc          (fetch_o_pc),
    .fetch_o_misalign    (fetch_o_misalign)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] pop_exp();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic test_reset();
    rst = 1; jump = 0; dstall = 0; ready = 1; resp_valid = 0;
    resp_data = '0; pc = 64'h80000000;
    cyc(); cyc();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %0b want 0", imem_req_valid); end
    checks++; if (fetch_o_valid !== 1'b0) begin errors++; $display("FAIL rst_fetch_valid: got %0b want 0", fetch_o_valid); end
    checks++; if (regF_stall !== 1'b0) begin errors++; $display("FAIL rst_regF_stall: got %0b want 0", regF_stall); end
    checks++; if ({fetch_o_pc, fetch_o_instr, fetch_o_misalign} !== '0) begin errors++; $display("FAIL rst_buffers: got pc=%h instr=%h mis=%0b want 0", fetch_o_pc, fetch_o_instr, fetch_o_misalign); end
    rst = 0; ready = 0;
  endtask

  task automatic test_basic();
    pc = 64'h80000000; ready = 1;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL basic_req_valid: got %0b want 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 64'h80000000) begin errors++; $display("FAIL basic_req_addr: got %h want 80000000", imem_req_addr); end
    checks++; if ({regF_stall, fetch_o_valid} !== 2'b10) begin errors++; $display("FAIL basic_req_cycle: got stall=%0b valid=%0b want 1/0", regF_stall, fetch_o_valid); end
    sb.push_back({pc, 32'h00500093});
    cyc();
    ready = 0; resp_valid = 1; resp_data = 32'h00500093;
    #1;
    checks++; if ({imem_req_valid, regF_stall, fetch_o_valid} !== 3'b010) begin errors++; $display("FAIL basic_wait_cycle: got req=%0b stall=%0b valid=%0b want 0/1/0", imem_req_valid, regF_stall, fetch_o_valid); end
    cyc();
    resp_valid = 0; resp_data = '1;
    #1;
    checks++; if ({fetch_o_valid, regF_stall} !== 2'b10) begin errors++; $display("FAIL basic_hold_cycle: got valid=%0b stall=%0b want 1/0", fetch_o_valid, regF_stall); end
    exp_e = pop_exp();
    checks++; if ({fetch_o_pc, fetch_o_instr} !== exp_e) begin errors++; $display("FAIL basic_data: got %h_%h want %h", fetch_o_pc, fetch_o_instr, exp_e); end
    cyc();
    #1;
    checks++; if (fetch_o_valid !== 1'b0) begin errors++; $display("FAIL basic_after_handoff: got valid=%0b want 0", fetch_o_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] inst;
    for (int i = 0; i < 3; i++) begin
      cyc();
      pc = 64'h80001000 + 64'(4 * i); inst = $urandom; ready = 1;
      #1;
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL b2b_req_valid[%0d]: got %0b want 1", i, imem_req_valid); end
      sb.push_back({pc, inst});
      cyc();
      ready = 0; resp_valid = 1; resp_data = inst;
      #1;
      checks++; if (fetch_o_valid !== 1'b0) begin errors++; $display("FAIL b2b_wait_valid[%0d]: got %0b want 0", i, fetch_o_valid); end
      cyc();
      resp_valid = 0;
      #1;
      checks++; if ({fetch_o_valid, regF_stall} !== 2'b10) begin errors++; $display("FAIL b2b_hold[%0d]: got valid=%0b stall=%0b want 1/0", i, fetch_o_valid, regF_stall); end
      exp_e = pop_exp();
      checks++; if ({fetch_o_pc, fetch_o_instr} !== exp_e) begin errors++; $display("FAIL b2b_data[%0d]: got %h_%h want %h", i, fetch_o_pc, fetch_o_instr, exp_e); end
    end
  endtask

  task automatic test_backpressure();
    cyc();
    pc = 64'h80002000; ready = 1;
    sb.push_back({pc, 32'h00A00513});
    cyc();
    ready = 0; resp_valid = 1; resp_data = 32'h00A00513;
    cyc();
    resp_valid = 0; resp_data = '0; dstall = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({fetch_o_valid, regF_stall} !== 2'b11) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%0b stall=%0b want 1/1", i, fetch_o_valid, regF_stall); end
      checks++; if ({fetch_o_pc, fetch_o_instr} !== sb[0]) begin errors++; $display("FAIL bp_stable[%0d]: got %h_%h want %h", i, fetch_o_pc, fetch_o_instr, sb[0]); end
      cyc();
    end
    dstall = 0;
    #1;
    checks++; if ({fetch_o_valid, regF_stall} !== 2'b10) begin errors++; $display("FAIL bp_handoff: got valid=%0b stall=%0b want 1/0", fetch_o_valid, regF_stall); end
    exp_e = pop_exp();
    checks++; if ({fetch_o_pc, fetch_o_instr} !== exp_e) begin errors++; $display("FAIL bp_data: got %h_%h want %h", fetch_o_pc, fetch_o_instr, exp_e); end
  endtask

  task automatic test_redirect_wait();
    cyc();
    pc = 64'h80003000; ready = 1;
    cyc();
    ready = 0; jump = 1;
    #1;
    checks++; if ({regF_stall, imem_req_valid} !== 2'b00) begin errors++; $display("FAIL rw_jump_cycle: got stall=%0b req=%0b want 0/0", regF_stall, imem_req_valid); end
    cyc();
    jump = 0; pc = 64'h80004000;
    #1;
    checks++; if ({imem_req_valid, fetch_o_valid, regF_stall} !== 3'b001) begin errors++; $display("FAIL rw_drain1: got req=%0b valid=%0b stall=%0b want 0/0/1", imem_req_valid, fetch_o_valid, regF_stall); end
    cyc();
    resp_valid = 1; resp_data = 32'hDEADBEEF;
    #1;
    checks++; if ({imem_req_valid, fetch_o_valid} !== 2'b00) begin errors++; $display("FAIL rw_drain2: got req=%0b valid=%0b want 0/0", imem_req_valid, fetch_o_valid); end
    cyc();
    resp_valid = 0; ready = 1;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h80004000) begin errors++; $display("FAIL rw_new_req: got req=%0b addr=%h want 1/80004000", imem_req_valid, imem_req_addr); end
    checks++; if (fetch_o_instr === 32'hDEADBEEF) begin errors++; $display("FAIL rw_stale_req: got instr=%h want not deadbeef", fetch_o_instr); end
    sb.push_back({pc, 32'h00100113});
    cyc();
    ready = 0; resp_valid = 1; resp_data = 32'h00100113;
    cyc();
    resp_valid = 0;
    #1;
    checks++; if (fetch_o_valid !== 1'b1) begin errors++; $display("FAIL rw_hold_valid: got %0b want 1", fetch_o_valid); end
    exp_e = pop_exp();
    checks++; if ({fetch_o_pc, fetch_o_instr} !== exp_e) begin errors++; $display("FAIL rw_data: got %h_%h want %h", fetch_o_pc, fetch_o_instr, exp_e); end
  endtask

  task automatic test_redirect_hold();
    cyc();
    pc = 64'h80008000; ready = 1;
    cyc();
    ready = 0; resp_valid = 1; resp_data = 32'h00200193;
    cyc();
    resp_valid = 0; jump = 1; dstall = 1;
    #1;
    checks++; if ({fetch_o_valid, regF_stall} !== 2'b10) begin errors++; $display("FAIL rh_jump_cycle: got valid=%0b stall=%0b want 1/0", fetch_o_valid, regF_stall); end
    cyc();
    jump = 0; dstall = 0;
    #1;
    checks++; if ({fetch_o_valid, imem_req_valid} !== 2'b01) begin errors++; $display("FAIL rh_after: got valid=%0b req=%0b want 0/1", fetch_o_valid, imem_req_valid); end
  endtask

  task automatic test_redirect_req();
    cyc();
    ready = 0; jump = 1; pc = 64'h80005000;
    #1;
    checks++; if ({imem_req_valid, regF_stall} !== 2'b00) begin errors++; $display("FAIL rq_jump_cycle: got req=%0b stall=%0b want 0/0", imem_req_valid, regF_stall); end
    cyc();
    jump = 0; pc = 64'h80006000;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h80006000 || regF_stall !== 1'b1) begin errors++; $display("FAIL rq_target_req: got req=%0b addr=%h stall=%0b want 1/80006000/1", imem_req_valid, imem_req_addr, regF_stall); end
    ready = 1;
    sb.push_back({pc, 32'h00300213});
    cyc();
    ready = 0; resp_valid = 1; resp_data = 32'h00300213;
    cyc();
    resp_valid = 0;
    #1;
    exp_e = pop_exp();
    checks++; if (fetch_o_valid !== 1'b1 || {fetch_o_pc, fetch_o_instr} !== exp_e) begin errors++; $display("FAIL rq_data: got valid=%0b %h_%h want 1 %h", fetch_o_valid, fetch_o_pc, fetch_o_instr, exp_e); end
  endtask

  task automatic test_reset_mid_wait();
    cyc();
    pc = 64'h80007000; ready = 1;
    cyc();
    ready = 0; rst = 1;
    #1;
    checks++; if ({imem_req_valid, fetch_o_valid, regF_stall} !== 3'b000) begin errors++; $display("FAIL rmw_during: got req=%0b valid=%0b stall=%0b want 0/0/0", imem_req_valid, fetch_o_valid, regF_stall); end
    cyc();
    rst = 0;
    #1;
    checks++; if ({fetch_o_pc, fetch_o_instr, fetch_o_misalign} !== '0) begin errors++; $display("FAIL rmw_cleared: got pc=%h instr=%h mis=%0b want 0", fetch_o_pc, fetch_o_instr, fetch_o_misalign); end
    checks++; if ({imem_req_valid, fetch_o_valid} !== 2'b10) begin errors++; $display("FAIL rmw_state_req: got req=%0b valid=%0b want 1/0", imem_req_valid, fetch_o_valid); end
  endtask

  task automatic test_misalign();
    cyc();
    pc = 64'h80000002; ready = 1;
    #1;
`ifdef FETCH_CTRL_MISALIGN_EN
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %0b want 0", imem_req_valid); end
    sb.push_back({64'h80000002, 32'h00000013});
    cyc();
    ready = 0;
    #1;
    exp_e = pop_exp();
    checks++; if ({fetch_o_valid, fetch_o_misalign} !== 2'b11) begin errors++; $display("FAIL mis_hold: got valid=%0b mis=%0b want 1/1", fetch_o_valid, fetch_o_misalign); end
    checks++; if ({fetch_o_pc, fetch_o_instr} !== exp_e) begin errors++; $display("FAIL mis_data: got %h_%h want %h", fetch_o_pc, fetch_o_instr, exp_e); end
`else
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h80000002) begin errors++; $display("FAIL mis_passthru: got req=%0b addr=%h want 1/80000002", imem_req_valid, imem_req_addr); end
    sb.push_back({pc, 32'h00400293});
    cyc();
    ready = 0; resp_valid = 1; resp_data = 32'h00400293;
    cyc();
    resp_valid = 0;
    #1;
    exp_e = pop_exp();
    checks++; if ({fetch_o_valid, fetch_o_misalign} !== 2'b10) begin errors++; $display("FAIL mis_hold: got valid=%0b mis=%0b want 1/0", fetch_o_valid, fetch_o_misalign); end
    checks++; if ({fetch_o_pc, fetch_o_instr} !== exp_e) begin errors++; $display("FAIL mis_data: got %h_%h want %h", fetch_o_pc, fetch_o_instr, exp_e); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_req();
    test_reset_mid_wait();
    test_misalign();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
